// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// MODE selects Mealy (combinational) or Moore (registered) detect timing.
package seq_det_pkg;

    localparam int MODE_MEALY = 0;
    localparam int MODE_MOORE = 1;

    // Fill counter must be able to hold the value SEQ_LEN itself.
    function automatic int fill_width(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign sat   = &cnt_q;

endmodule

// File: rtl/param_seq_detector.sv
// Serial bit-pattern detector with runtime pattern and overlap control,
// build-time Mealy/Moore output timing and a saturating match counter.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int MODE    = MODE_MEALY
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               data_in,
    input  logic [SEQ_LEN-1:0] pattern,
    input  logic               overlap_en,
    input  logic               clear_cnt,
    output logic               seq_detected,
    output logic [SEQ_LEN-1:0] current_seq,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_sat
);

    localparam int FILL_W = fill_width(SEQ_LEN);

    logic [SEQ_LEN-1:0] hist_q;
    logic [SEQ_LEN-1:0] hist_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [SEQ_LEN-1:0] cand;
    logic               match;

    // Candidate word includes the bit arriving this cycle.
    assign cand  = {hist_q[SEQ_LEN-2:0], data_in};
    assign match = enable && (fill_q >= FILL_W'(SEQ_LEN - 1)) && (cand == pattern);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (enable) begin
            hist_d = cand;
            if (match && !overlap_en) begin
                fill_d = '0;
            end else if (fill_q != FILL_W'(SEQ_LEN)) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    generate
        if (MODE == MODE_MOORE) begin : g_moore
            logic det_q;
            logic det_d;

            always_comb begin
                det_d = match;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    det_q <= 1'b0;
                end else begin
                    det_q <= det_d;
                end
            end

            assign seq_detected = det_q;
        end else begin : g_mealy
            // Gate with reset so the combinational pulse cannot leak during reset.
            assign seq_detected = reset_n & match;
        end
    endgenerate

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (match),
        .clr    (clear_cnt),
        .count  (match_count),
        .sat    (cnt_sat)
    );

    assign current_seq = hist_q;

endmodule
